// File: rtl/apb_register_bank_if.sv
// APB3 bus bundle for apb_register_bank.
//   master modport: drives psel/penable/pwrite/paddr/pwdata; receives
//                   prdata/pready/pslverr.
//   slave modport : the mirror image, used by the register bank.
// Parameter APB_AW sets the PADDR width.
interface apb_register_bank_if #(
  parameter int unsigned APB_AW = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_register_bank.sv
// apb_register_bank: APB3 slave with the burst configuration registers and a
// byte-wide data memory that feeds / receives the data burst controller.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   apb (slave modport)   psel/penable/pwrite/paddr/pwdata in,
//                         prdata/pready/pslverr out
//   rb_db_start           one-cycle transfer start pulse
//   rb_db_rw              1 = memory->burst, 0 = burst->memory
//   rb_db_max_burst_size  MAX_BURST register
//   rb_db_length          LENGTH register
//   rb_db_data, rb_db_ack memory byte and request acknowledge to controller
//   db_rb_req/addr/data   controller request, address and store byte
//   db_rb_idle            controller idle level
//   db_rb_rd_done         read transfer complete level
//   irq                   only with RB_IRQ_EN: IE & (DONE | ERR), registered
//
// Optional feature macro: RB_IRQ_EN (adds irq output and CTRL bit2 IE).
//
// Map: 0x000 CTRL, 0x004 MAX_BURST, 0x008 LENGTH, 0x00C STATUS,
//      0x800 + n data byte n. Anything else answers with pslverr.
module apb_register_bank #(
  parameter int unsigned MEM_AW = 9,
  parameter int unsigned APB_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_register_bank_if.slave apb,
  output logic               rb_db_start,
  output logic               rb_db_rw,
  output logic [7:0]         rb_db_max_burst_size,
  output logic [7:0]         rb_db_length,
  output logic [7:0]         rb_db_data,
  output logic               rb_db_ack,
  input  logic               db_rb_req,
  input  logic [8:0]         db_rb_addr,
  input  logic [7:0]         db_rb_data,
  input  logic               db_rb_idle,
  input  logic               db_rb_rd_done
`ifdef RB_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_ACCESS   = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT = 2'd3;

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  logic [7:0]        mem [DEPTH];
  logic [1:0]        state_q, state_cur, state_d;
  logic              rw_q, start_q, done_q, err_q, ack_q;
  logic [7:0]        max_q, len_q, data_q, mem_rdata_q;
  logic              mem_rd_ok_q, idle_q, rd_done_q, started_q;
  logic              ie;

  logic              sel_ctrl, sel_max, sel_len, sel_stat, sel_mem, addr_ok;
  logic              busy, acc, acc_err, wr, start_req, start_ok;
  logic              done_set, err_set, idle_rise;
  logic [7:0]        rd_val;
  logic [MEM_AW-1:0] mem_idx, db_idx;
  logic              unused_ok;

  assign unused_ok = ^{apb.pwdata[31:8], db_rb_addr};

  assign sel_ctrl = (apb.paddr == APB_AW'('h000));
  assign sel_max  = (apb.paddr == APB_AW'('h004));
  assign sel_len  = (apb.paddr == APB_AW'('h008));
  assign sel_stat = (apb.paddr == APB_AW'('h00C));
  assign sel_mem  = apb.paddr[APB_AW-1] && ((apb.paddr[APB_AW-2:0] >> MEM_AW) == '0);
  assign addr_ok  = sel_ctrl | sel_max | sel_len | sel_stat | sel_mem;
  assign mem_idx  = apb.paddr[MEM_AW-1:0];
  assign db_idx   = db_rb_addr[MEM_AW-1:0];
  assign busy     = ~db_rb_idle;

  // The setup phase is recognised in the same cycle it appears on the bus, so
  // SETUP is overlaid on the registered IDLE state rather than stored; the
  // registered state then tracks the access phase (ACCESS or MEM_WAIT).
  always_comb begin
    state_cur = state_q;
    if (state_q == ST_IDLE && apb.psel && !apb.penable) state_cur = ST_SETUP;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_cur)
      ST_SETUP:    state_d = (sel_mem && !apb.pwrite && !busy) ? ST_MEM_WAIT : ST_ACCESS;
      ST_MEM_WAIT: state_d = ST_ACCESS;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign acc = (state_cur == ST_ACCESS) && apb.psel && apb.penable;

  // A memory read is only served if it went through the wait state; one that
  // arrived while busy skipped it and is answered with an error.
  always_comb begin
    acc_err = 1'b0;
    if (!addr_ok)                              acc_err = 1'b1;
    else if (sel_mem && !apb.pwrite)           acc_err = !mem_rd_ok_q;
    else if (apb.pwrite && !sel_stat && busy)  acc_err = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    if (sel_ctrl)      rd_val = {5'b0, ie, rw_q, 1'b0};
    else if (sel_max)  rd_val = max_q;
    else if (sel_len)  rd_val = len_q;
    else if (sel_stat) rd_val = {5'b0, err_q, done_q, db_rb_idle};
    else if (sel_mem)  rd_val = mem_rdata_q;
  end

  assign apb.pready  = (state_cur != ST_MEM_WAIT);
  assign apb.pslverr = acc && acc_err;
  assign apb.prdata  = (acc && !apb.pwrite && !acc_err) ? {24'b0, rd_val} : '0;

  assign wr        = acc && apb.pwrite && !acc_err;
  assign start_req = wr && sel_ctrl && apb.pwdata[0];
  assign start_ok  = start_req && (len_q != 8'd0) && (max_q != 8'd0);
  assign err_set   = start_req && !start_ok;
  assign idle_rise = db_rb_idle && !idle_q;
  assign done_set  = (db_rb_rd_done && !rd_done_q) || (started_q && idle_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      max_q       <= 8'd4;
      len_q       <= 8'd0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      data_q      <= 8'd0;
      mem_rd_ok_q <= 1'b0;
      idle_q      <= 1'b1;
      rd_done_q   <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_ok;
      idle_q    <= db_rb_idle;
      rd_done_q <= db_rb_rd_done;
      ack_q     <= db_rb_req;
      if (db_rb_req && rw_q) data_q <= mem[db_idx];

      if (state_cur == ST_MEM_WAIT)    mem_rd_ok_q <= 1'b1;
      else if (state_cur == ST_ACCESS) mem_rd_ok_q <= 1'b0;

      if (wr && sel_ctrl) rw_q  <= apb.pwdata[1];
      if (wr && sel_max)  max_q <= apb.pwdata[7:0];
      if (wr && sel_len)  len_q <= apb.pwdata[7:0];

      if (start_ok)       started_q <= 1'b1;
      else if (idle_rise) started_q <= 1'b0;

      // Set events take priority over a same-cycle W1C clear.
      if (done_set)                                done_q <= 1'b1;
      else if (wr && sel_stat && apb.pwdata[1])    done_q <= 1'b0;
      if (err_set)                                 err_q  <= 1'b1;
      else if (wr && sel_stat && apb.pwdata[2])    err_q  <= 1'b0;
    end
  end

  // Memory has no reset; APB and controller never write it in the same cycle.
  always_ff @(posedge clk) begin
    if (wr && sel_mem)                         mem[mem_idx] <= apb.pwdata[7:0];
    else if (rst_n && db_rb_req && !rw_q)      mem[db_idx]  <= db_rb_data;
    if (state_cur == ST_MEM_WAIT)              mem_rdata_q  <= mem[mem_idx];
  end

`ifdef RB_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr && sel_ctrl) ie_q <= apb.pwdata[2];
      irq_q <= ie_q & (done_q | err_q);
    end
  end
  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie = 1'b0;
`endif

  assign rb_db_start          = start_q;
  assign rb_db_rw             = rw_q;
  assign rb_db_max_burst_size = max_q;
  assign rb_db_length         = len_q;
  assign rb_db_data           = data_q;
  assign rb_db_ack            = ack_q;

endmodule

// File: tb/tb_apb_register_bank.sv
`timescale 1ns/1ps
module tb_apb_register_bank;

  logic       clk;
  logic       rst_n;
  logic       rb_db_start, rb_db_rw, rb_db_ack;
  logic [7:0] rb_db_max_burst_size, rb_db_length, rb_db_data;
  logic       db_rb_req;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_idle, db_rb_rd_done;
`ifdef RB_IRQ_EN
  logic       irq;
`endif

  apb_register_bank_if #(.APB_AW(12)) bus ();

  apb_register_bank #(.MEM_AW(9), .APB_AW(12)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .apb                  (bus),
    .rb_db_start          (rb_db_start),
    .rb_db_rw             (rb_db_rw),
    .rb_db_max_burst_size (rb_db_max_burst_size),
    .rb_db_length         (rb_db_length),
    .rb_db_data           (rb_db_data),
    .rb_db_ack            (rb_db_ack),
    .db_rb_req            (db_rb_req),
    .db_rb_addr           (db_rb_addr),
    .db_rb_data           (db_rb_data),
    .db_rb_idle           (db_rb_idle),
    .db_rb_rd_done        (db_rb_rd_done)
`ifdef RB_IRQ_EN
    ,
    .irq                  (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  always @(posedge clk) if (rb_db_start === 1'b1) start_cnt++;

  // Reference model: register values, sticky flags and memory image.
  logic [7:0] m_mem [512];
  logic [7:0] m_max, m_len, m_last_data;
  bit         m_rw, m_done, m_err;
  int unsigned written [$];

  task automatic model_reset();
    m_max = 8'd4; m_len = 8'd0; m_last_data = 8'd0;
    m_rw = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    waits = 0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1;
    while (bus.pready !== 1'b1 && waits < 8) begin
      @(posedge clk); #2;
      waits++;
    end
    if (bus.pready !== 1'b1) begin
      total++; bad++;
      $display("FAIL apb_timeout addr=%h pready=%b required=1", addr, bus.pready);
    end
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] d; int w;
    apb_xfer(1'b1, addr, wdata, d, err, w);
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err,
                          output int waits);
    apb_xfer(1'b0, addr, 32'h0, data, err, waits);
  endtask

  function automatic logic [31:0] exp_status();
    return {29'b0, m_err, m_done, db_rb_idle};
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic e; int w;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.prdata, bus.pready, bus.pslverr, rb_db_start, rb_db_rw, rb_db_max_burst_size,
         rb_db_length, rb_db_data, rb_db_ack} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b start=%b rw=%b max=%h len=%h data=%h ack=%b",
               bus.prdata, bus.pready, bus.pslverr, rb_db_start, rb_db_rw, rb_db_max_burst_size,
               rb_db_length, rb_db_data, rb_db_ack);
    end
`ifdef RB_IRQ_EN
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status() || e !== 1'b0) begin
      bad++; $display("FAIL reset_status got=%h err=%b exp=%h err=0", d, e, exp_status());
    end
  endtask

  task automatic test_start();
    logic e; int c0;
    apb_write(12'h004, 32'h4, e); m_max = 8'd4;
    apb_write(12'h008, 32'h3, e); m_len = 8'd3;
    c0 = start_cnt;
    apb_write(12'h000, 32'h3, e); m_rw = 1'b1;
    total++;
    if ({rb_db_start, rb_db_rw, rb_db_length, rb_db_max_burst_size, e} !== {1'b1, m_rw, m_len, m_max, 1'b0}) begin
      bad++;
      $display("FAIL start_pulse got start=%b rw=%b len=%h max=%h err=%b exp 1 %b %h %h 0",
               rb_db_start, rb_db_rw, rb_db_length, rb_db_max_burst_size, e, m_rw, m_len, m_max);
    end
    @(posedge clk); #1;
    total++;
    if (rb_db_start !== 1'b0 || start_cnt - c0 !== 1) begin
      bad++; $display("FAIL start_one_cycle got start=%b pulses=%0d exp 0 and 1", rb_db_start, start_cnt - c0);
    end
  endtask

  task automatic test_write_transfer();
    logic e; logic [31:0] d; int w;
    logic [7:0] pre [3];
    pre[0] = 8'hA1; pre[1] = 8'hB2; pre[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      apb_write(12'h800 + 12'(i), {24'h0, pre[i]}, e);
      m_mem[i] = pre[i]; written.push_back(i);
    end
    apb_write(12'h000, 32'h3, e);
    db_rb_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      db_rb_req = 1'b1; db_rb_addr = 9'(i);
      @(posedge clk); #1;
      m_last_data = m_mem[i];
      total++;
      if (rb_db_ack !== 1'b1 || rb_db_data !== m_last_data) begin
        bad++; $display("FAIL wr_xfer_ack%0d got ack=%b data=%h exp 1 %h", i, rb_db_ack, rb_db_data, m_last_data);
      end
    end
    db_rb_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rb_db_ack !== 1'b0) begin bad++; $display("FAIL wr_xfer_ack_drop got=%b exp=0", rb_db_ack); end
    db_rb_idle = 1'b1;
    m_done = 1'b1;
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== 32'h3 || d !== exp_status()) begin
      bad++; $display("FAIL wr_xfer_done got=%h exp=%h", d, exp_status());
    end
    apb_write(12'h00C, 32'h2, e); m_done = 1'b0;
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status()) begin bad++; $display("FAIL done_w1c got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_read_transfer();
    logic e; logic [31:0] d; int w;
    logic [8:0] ad [2]; logic [7:0] dt [2];
    ad[0] = 9'd5; dt[0] = 8'h5A; ad[1] = 9'd6; dt[1] = 8'h6B;
    apb_write(12'h000, 32'h1, e); m_rw = 1'b0;
    total++;
    if (rb_db_start !== 1'b1 || rb_db_rw !== 1'b0) begin
      bad++; $display("FAIL rd_xfer_start got start=%b rw=%b exp 1 0", rb_db_start, rb_db_rw);
    end
    db_rb_idle = 1'b0;
    for (int i = 0; i < 2; i++) begin
      db_rb_req = 1'b1; db_rb_addr = ad[i]; db_rb_data = dt[i];
      @(posedge clk); #1;
      m_mem[ad[i]] = dt[i]; written.push_back(int'(ad[i]));
      total++;
      if (rb_db_ack !== 1'b1 || rb_db_data !== m_last_data) begin
        bad++; $display("FAIL rd_xfer_ack%0d got ack=%b data=%h exp 1 %h", i, rb_db_ack, rb_db_data, m_last_data);
      end
    end
    db_rb_req = 1'b0;
    db_rb_rd_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    db_rb_idle = 1'b1;
    m_done = 1'b1;
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== 32'h3 || d !== exp_status()) begin bad++; $display("FAIL rd_done_status got=%h exp=3", d); end
    db_rb_rd_done = 1'b0;
    apb_read(12'h805, d, e, w);
    total++;
    if (d !== {24'h0, m_mem[5]} || e !== 1'b0 || w !== 1) begin
      bad++; $display("FAIL mem_read_805 got=%h err=%b waits=%0d exp=%h err=0 waits=1", d, e, w, m_mem[5]);
    end
  endtask

  task automatic test_busy();
    logic e; logic [31:0] d; int w;
    db_rb_idle = 1'b0;
    apb_write(12'h008, 32'h9, e);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL busy_len_write err got=%b exp=1", e); end
    apb_read(12'h008, d, e, w);
    total++;
    if (d !== {24'h0, m_len} || e !== 1'b0) begin
      bad++; $display("FAIL busy_len_unchanged got=%h err=%b exp=%h err=0", d, e, m_len);
    end
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status() || d[0] !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL busy_status got=%h err=%b exp=%h err=0", d, e, exp_status());
    end
    apb_read(12'h800, d, e, w);
    total++;
    if (e !== 1'b1 || d !== 32'h0 || w !== 0) begin
      bad++; $display("FAIL busy_mem_read got=%h err=%b waits=%0d exp=0 err=1 waits=0", d, e, w);
    end
    apb_write(12'h800, 32'h77, e);
    db_rb_idle = 1'b1;
    apb_read(12'h800, d, e, w);
    total++;
    if (d !== {24'h0, m_mem[0]} || e !== 1'b0) begin
      bad++; $display("FAIL busy_mem_write_blocked got=%h exp=%h", d, m_mem[0]);
    end
    apb_write(12'h00C, 32'h2, e); m_done = 1'b0;
  endtask

  task automatic test_start_error();
    logic e; logic [31:0] d; int w; int c0;
    c0 = start_cnt;
    apb_write(12'h008, 32'h0, e); m_len = 8'd0;
    apb_write(12'h000, 32'h5, e); m_rw = 1'b0; m_err = 1'b1;
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL len0_pslverr got=%b exp=0", e); end
`ifdef RB_IRQ_EN
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_assert got=%b exp=1", irq); end
`endif
    apb_read(12'h000, d, e, w);
    total++;
`ifdef RB_IRQ_EN
    if (d !== 32'h4) begin bad++; $display("FAIL ctrl_readback got=%h exp=4", d); end
`else
    if (d !== 32'h0) begin bad++; $display("FAIL ctrl_readback got=%h exp=0", d); end
`endif
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status() || start_cnt != c0) begin
      bad++; $display("FAIL len0_err got=%h pulses=%0d exp=%h pulses=0", d, start_cnt - c0, exp_status());
    end
    apb_write(12'h00C, 32'h4, e); m_err = 1'b0;
`ifdef RB_IRQ_EN
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    apb_write(12'h000, 32'h0, e);
`endif
    apb_write(12'h008, 32'h3, e); m_len = 8'd3;
    apb_write(12'h004, 32'h0, e); m_max = 8'd0;
    apb_write(12'h000, 32'h1, e); m_err = 1'b1;
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status() || start_cnt != c0) begin
      bad++; $display("FAIL max0_err got=%h pulses=%0d exp=%h pulses=0", d, start_cnt - c0, exp_status());
    end
    apb_write(12'h00C, 32'h4, e); m_err = 1'b0;
    apb_write(12'h004, 32'h4, e); m_max = 8'd4;
  endtask

  task automatic test_illegal();
    logic e; logic [31:0] d; int w;
    logic [11:0] bad_addr [3];
    bad_addr[0] = 12'h010; bad_addr[1] = 12'hA00; bad_addr[2] = 12'h003;
    for (int i = 0; i < 3; i++) begin
      apb_read(bad_addr[i], d, e, w);
      total++;
      if (e !== 1'b1 || d !== 32'h0) begin
        bad++; $display("FAIL illegal_read %h got=%h err=%b exp=0 err=1", bad_addr[i], d, e);
      end
    end
    apb_write(12'h010, 32'hFF, e);
    apb_read(12'h008, d, e, w);
    total++;
    if (d !== {24'h0, m_len}) begin bad++; $display("FAIL illegal_noeffect got=%h exp=%h", d, m_len); end
  endtask

  task automatic test_random();
    logic e; logic [31:0] d; int w;
    int unsigned op, a;
    logic [7:0] v;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          a = $urandom_range(0, 511); v = 8'($urandom);
          apb_write(12'h800 + 12'(a), {24'h0, v}, e);
          m_mem[a] = v; written.push_back(a);
          total++;
          if (e !== 1'b0) begin bad++; $display("FAIL rnd_mem_write err got=%b exp=0", e); end
        end
        1: begin
          a = written[$urandom_range(0, written.size() - 1)];
          apb_read(12'h800 + 12'(a), d, e, w);
          total++;
          if (d !== {24'h0, m_mem[a]} || e !== 1'b0 || w !== 1) begin
            bad++; $display("FAIL rnd_mem_read[%0d] got=%h waits=%0d exp=%h waits=1", a, d, w, m_mem[a]);
          end
        end
        2: begin
          v = 8'($urandom);
          if ($urandom_range(0, 1) == 0) begin
            apb_write(12'h004, {24'h0, v}, e); m_max = v;
          end else begin
            apb_write(12'h008, {24'h0, v}, e); m_len = v;
          end
          apb_read(12'h004, d, e, w);
          total++;
          if (d[7:0] !== m_max || rb_db_max_burst_size !== m_max || rb_db_length !== m_len) begin
            bad++; $display("FAIL rnd_regs got max=%h/%h len=%h exp max=%h len=%h",
                            d[7:0], rb_db_max_burst_size, rb_db_length, m_max, m_len);
          end
        end
        3: begin
          apb_write(12'h000, 32'h2, e); m_rw = 1'b1;
          a = written[$urandom_range(0, written.size() - 1)];
          db_rb_req = 1'b1; db_rb_addr = 9'(a);
          @(posedge clk); #1;
          db_rb_req = 1'b0;
          m_last_data = m_mem[a];
          total++;
          if (rb_db_ack !== 1'b1 || rb_db_data !== m_last_data) begin
            bad++; $display("FAIL rnd_ctrl_fetch[%0d] got ack=%b data=%h exp 1 %h", a, rb_db_ack, rb_db_data, m_last_data);
          end
        end
        default: begin
          apb_write(12'h000, 32'h0, e); m_rw = 1'b0;
          a = $urandom_range(0, 511); v = 8'($urandom);
          db_rb_req = 1'b1; db_rb_addr = 9'(a); db_rb_data = v;
          @(posedge clk); #1;
          db_rb_req = 1'b0;
          m_mem[a] = v; written.push_back(a);
          total++;
          if (rb_db_ack !== 1'b1 || rb_db_data !== m_last_data) begin
            bad++; $display("FAIL rnd_ctrl_store[%0d] got ack=%b data=%h exp 1 %h", a, rb_db_ack, rb_db_data, m_last_data);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic e; logic [31:0] d; int w;
    apb_write(12'h008, 32'h5, e);
    apb_write(12'h004, 32'h2, e);
    apb_write(12'h000, 32'h3, e);
    db_rb_idle = 1'b0;
    db_rb_req = 1'b1; db_rb_addr = 9'd1;
    @(posedge clk); #1;
    total++;
    if (rb_db_ack !== 1'b1) begin bad++; $display("FAIL mid_ack_before_reset got=%b exp=1", rb_db_ack); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.prdata, bus.pready, bus.pslverr, rb_db_start, rb_db_rw, rb_db_max_burst_size,
         rb_db_length, rb_db_data, rb_db_ack} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_outputs got start=%b rw=%b max=%h len=%h data=%h ack=%b",
               rb_db_start, rb_db_rw, rb_db_max_burst_size, rb_db_length, rb_db_data, rb_db_ack);
    end
`ifdef RB_IRQ_EN
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
`endif
    db_rb_req = 1'b0; db_rb_idle = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    apb_read(12'h00C, d, e, w);
    total++;
    if (d !== exp_status()) begin bad++; $display("FAIL mid_reset_status got=%h exp=%h", d, exp_status()); end
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    db_rb_req = 1'b0; db_rb_addr = '0; db_rb_data = '0; db_rb_idle = 1'b1; db_rb_rd_done = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_write_transfer();
    test_read_transfer();
    test_busy();
    test_start_error();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
